calculator_pipe: RTL and testbench
==================================

CALCULATOR_PIPE -- requirements
Module: calculator_pipe

Interface
REQ-001 Parameter BIT_WIDTH, default 8, operand/result width in bits (≥2) SHALL be provided.
REQ-002 Parameter PIPE_STAGES, default 2, accept-to-result latency in cycles (1..4) SHALL be provided.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/operation presented.
REQ-006 in_ready  output  1  block can accept this cycle.
REQ-007 a  input  BIT_WIDTH  operand A.
REQ-008 b  input  BIT_WIDTH  operand B.
REQ-009 operation  input  te_operation  requested operation.
REQ-010 out_valid  output  1  result/status valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 result  output  BIT_WIDTH  operation result.
REQ-013 status  output  te_out_status  result status.

Function
REQ-014 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-015 Operations: ADD a+b, SUB a-b, AND, OR, XOR bitwise; ACC acc+a (b ignored), acc updated; CLR acc<=0, result 0; result modulo 2^BIT_WIDTH.
REQ-016 Encoding 7 SHALL be invalid: result 0, status ST_INVALID, accumulator unchanged.
REQ-017 Overflow: ADD/ACC unsigned carry-out; SUB borrow (a<b); never for logic ops/CLR.
REQ-018 Status priority: ST_INVALID > ST_OVERFLOW > ST_ZERO (result==0) > ST_OK.
REQ-019 Result/status computed at acceptance, then carried through PIPE_STAGES valid-tagged registers; out_valid asserts exactly PIPE_STAGES cycles after accept when unstalled.
REQ-020 Accumulator updates in the accept cycle, so back-to-back ACC ops see each predecessor's value (no hazard).
REQ-021 Stall: in_ready = !(out_valid && !out_ready); while stalled all pipeline registers and accumulator hold.
REQ-022 Bubbles are not compressed; invalid slots advance with valid ones when unstalled.
REQ-023 Results SHALL leave in acceptance order, none lost or duplicated under any out_ready pattern.
REQ-024 result/status SHALL be held stable while out_valid && !out_ready.
REQ-025 Full throughput: one accept and one delivery per cycle when out_ready stays high.

Reset
REQ-026 Reset SHALL asynchronously clear all stage valid bits, accumulator to 0, result to 0, status to ST_OK.
REQ-027 During reset: out_valid=0, in_ready=0; in_ready=1 first cycle after deassertion.
REQ-028 Reset mid-operation SHALL discard every in-flight result; none emerges afterwards.

Structure
REQ-029 calculator_pkg SHALL hold te_operation (3-bit enum: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_ACC=5, OP_CLR=6) and te_out_status (2-bit: ST_OK=0, ST_ZERO=1, ST_OVERFLOW=2, ST_INVALID=3).
REQ-030 Combinational op/flag logic SHALL live in sub-module calculator_alu (BIT_WIDTH param, inputs a, b, acc, operation; outputs result, status, acc_next); pipeline, handshake and accumulator stay in calculator_pipe.

Verification (BIT_WIDTH=8, PIPE_STAGES=2 unless noted)
REQ-031 ADD a=8 b=16, out_ready=1 -> result 24, ST_OK, out_valid exactly 2 cycles after accept.
REQ-032 ADD 200+100 -> 44 ST_OVERFLOW; SUB 5-5 -> 0 ST_ZERO; SUB 3-5 -> 254 ST_OVERFLOW; op code 7 -> 0 ST_INVALID.
REQ-033 Back-to-back CLR, ACC 10, ACC 20, ACC 250 -> results 0 ST_ZERO, 10 ST_OK, 30 ST_OK, 24 ST_OVERFLOW in consecutive cycles.
REQ-034 Stream ADD 1+1, 2+2, 3+3, 4+4 with out_ready low 3 cycles after first out_valid -> in_ready low while stalled, outputs held, delivered 2,4,6,8 in order, no duplicates.
REQ-035 Reset asserted with 2 ops in flight -> out_valid drops immediately; after release no stale result emerges, ACC 5 returns 5.
REQ-036 PIPE_STAGES=1 and 4 rerun of REQ-031 -> latency 1 and 4 cycles respectively.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared types for the calculator pipeline.
//   te_operation  : 3-bit operation code (encoding 7 is unused and treated as invalid)
//   te_out_status : 2-bit result status
//   pick_status   : applies status priority INVALID > OVERFLOW > ZERO > OK
package calculator_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_ACC = 3'd5,
    OP_CLR = 3'd6
  } te_operation;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_ZERO     = 2'd1,
    ST_OVERFLOW = 2'd2,
    ST_INVALID  = 2'd3
  } te_out_status;

  function automatic te_out_status pick_status(input logic invalid,
                                               input logic overflow,
                                               input logic zero);
    if (invalid) return ST_INVALID;
    if (overflow) return ST_OVERFLOW;
    if (zero) return ST_ZERO;
    return ST_OK;
  endfunction

endpackage

// File: rtl/calculator_alu.sv
// Combinational operation and status logic for calculator_pipe.
//   a, b      : operands
//   acc       : current accumulator value
//   operation : requested operation
//   result    : operation result, modulo 2^BIT_WIDTH
//   status    : prioritised result status
//   acc_next  : accumulator value if this operation is accepted
module calculator_alu
  import calculator_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic [BIT_WIDTH-1:0] acc,
  input  te_operation          operation,
  output logic [BIT_WIDTH-1:0] result,
  output te_out_status         status,
  output logic [BIT_WIDTH-1:0] acc_next
);

  // One extra bit exposes the unsigned carry-out.
  logic [BIT_WIDTH:0] add_w;
  logic [BIT_WIDTH:0] acc_w;
  logic               ovf;
  logic               inv;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign acc_w = {1'b0, acc} + {1'b0, a};

  always_comb begin
    result   = '0;
    ovf      = 1'b0;
    inv      = 1'b0;
    acc_next = acc;
    case (operation)
      OP_ADD: begin
        result = add_w[BIT_WIDTH-1:0];
        ovf    = add_w[BIT_WIDTH];
      end
      OP_SUB: begin
        result = a - b;
        ovf    = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ACC: begin
        result   = acc_w[BIT_WIDTH-1:0];
        ovf      = acc_w[BIT_WIDTH];
        acc_next = acc_w[BIT_WIDTH-1:0];
      end
      OP_CLR: begin
        result   = '0;
        acc_next = '0;
      end
      default: inv = 1'b1;
    endcase
    status = pick_status(inv, ovf, result == '0);
  end

endmodule

// File: rtl/calculator_pipe.sv
// Pipelined calculator with valid/ready handshakes on both sides.
// Result and status are computed when an operation is accepted and then
// travel through PIPE_STAGES valid-tagged registers; a stalled output
// freezes the whole pipeline and the accumulator.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake
//   a, b, operation      : operands and operation
//   out_valid / out_ready: output handshake
//   result, status       : result and status of the oldest slot
module calculator_pipe
  import calculator_pkg::*;
#(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  te_operation          operation,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] result,
  output te_out_status         status
);

  logic [PIPE_STAGES-1:0] vld_q;
  logic [BIT_WIDTH-1:0]   res_q [PIPE_STAGES];
  te_out_status           st_q  [PIPE_STAGES];
  logic [BIT_WIDTH-1:0]   acc_q;
  logic [BIT_WIDTH-1:0]   acc_d;
  logic [BIT_WIDTH-1:0]   alu_res;
  te_out_status           alu_st;
  logic                   stall;
  logic                   accept;

  calculator_alu #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_alu (
    .a        (a),
    .b        (b),
    .acc      (acc_q),
    .operation(operation),
    .result   (alu_res),
    .status   (alu_st),
    .acc_next (acc_d)
  );

  assign out_valid = vld_q[PIPE_STAGES-1];
  assign result    = res_q[PIPE_STAGES-1];
  assign status    = st_q[PIPE_STAGES-1];

  // Only a held output stalls; bubbles are never squeezed out.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !reset && !stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      acc_q <= '0;
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
        res_q[i] <= '0;
        st_q[i]  <= ST_OK;
      end
    end else if (!stall) begin
      vld_q[0] <= accept;
      if (accept) begin
        res_q[0] <= alu_res;
        st_q[0]  <= alu_st;
        acc_q    <= acc_d;
      end
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
        st_q[i]  <= st_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_calculator_pipe.sv
module tb_calculator_pipe;
  import calculator_pkg::*;

  typedef struct {
    logic [7:0]   res;
    te_out_status st;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  te_operation op;
  logic        out_ready;

  logic         in_ready, out_valid;
  logic [7:0]   result;
  te_out_status status;
  logic         in_ready1, out_valid1;
  logic [7:0]   result1;
  te_out_status status1;
  logic         in_ready4, out_valid4;
  logic [7:0]   result4;
  te_out_status status4;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;

  bit           hold_pend = 0;
  logic [7:0]   prev_res;
  te_out_status prev_st;

  bit           lat_arm = 0;
  bit           seen1 = 0, seen4 = 0;
  int           cyc1 = 0, cyc4 = 0;
  logic [7:0]   res1_s, res4_s;
  te_out_status st1_s, st4_s;

  calculator_pipe #(.BIT_WIDTH(8), .PIPE_STAGES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .operation(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .status(status));

  calculator_pipe #(.BIT_WIDTH(8), .PIPE_STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .operation(op), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .status(status1));

  calculator_pipe #(.BIT_WIDTH(8), .PIPE_STAGES(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .operation(op), .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .status(status4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each output transfer and checks that a
  // held output stays stable.
  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_result", int'(result), int'(prev_res));
        check("hold_status", int'(status), int'(prev_st));
      end
      hold_pend = out_valid && !out_ready;
      prev_res  = result;
      prev_st   = status;
      if (out_valid && out_ready) begin
        check("out_has_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("result", int'(result), int'(e.res));
          check("status", int'(status), int'(e.st));
          if (e.chk_lat) check("latency", cyc - e.acc_cyc, 2);
        end
      end
    end
  end

  // First-output capture for the PIPE_STAGES=1 and 4 instances.
  always @(negedge clk) begin
    if (!reset && lat_arm) begin
      if (out_valid1 && !seen1) begin
        seen1 = 1; cyc1 = cyc; res1_s = result1; st1_s = status1;
      end
      if (out_valid4 && !seen4) begin
        seen4 = 1; cyc4 = cyc; res4_s = result4; st4_s = status4;
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
  task automatic send(input te_operation o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] r, input te_out_status s, input bit lat);
    int unsigned g;
    exp_t e;
    g = 0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    while (!in_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("accept_wait", int'(in_ready), 1);
    end else begin
      e.res = r; e.st = s; e.acc_cyc = cyc; e.chk_lat = lat;
      last_acc_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned g;
    g = 0;
    while (sb.size() != 0 && g < 60) begin
      @(posedge clk);
      g++;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = OP_ADD;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_result", int'(result), 0);
    check("rst_status", int'(status), int'(ST_OK));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);

    // Basic latency, also on PIPE_STAGES=1 and 4.
    lat_arm = 1;
    send(OP_ADD, 8'd8, 8'd16, 8'd24, ST_OK, 1);
    repeat (6) @(posedge clk);
    #1;
    lat_arm = 0;
    check("p1_seen", int'(seen1), 1);
    check("p1_latency", cyc1 - last_acc_cyc, 1);
    check("p1_result", int'(res1_s), 24);
    check("p1_status", int'(st1_s), int'(ST_OK));
    check("p4_seen", int'(seen4), 1);
    check("p4_latency", cyc4 - last_acc_cyc, 4);
    check("p4_result", int'(res4_s), 24);
    check("p4_status", int'(st4_s), int'(ST_OK));
    drain();

    // Arithmetic / logic / status corners, back to back.
    send(OP_ADD, 8'd200, 8'd100, 8'd44, ST_OVERFLOW, 1);
    send(OP_SUB, 8'd5, 8'd5, 8'd0, ST_ZERO, 1);
    send(OP_SUB, 8'd3, 8'd5, 8'd254, ST_OVERFLOW, 1);
    send(te_operation'(3'd7), 8'd12, 8'd34, 8'd0, ST_INVALID, 1);
    send(OP_AND, 8'hF0, 8'h3C, 8'h30, ST_OK, 1);
    send(OP_OR, 8'hF0, 8'h0F, 8'hFF, ST_OK, 1);
    send(OP_XOR, 8'hAA, 8'hAA, 8'h00, ST_ZERO, 1);
    send(OP_ADD, 8'd255, 8'd1, 8'd0, ST_OVERFLOW, 1);
    drain();

    // Accumulator chain; invalid op must leave it untouched.
    send(OP_CLR, 8'd77, 8'd3, 8'd0, ST_ZERO, 1);
    send(OP_ACC, 8'd10, 8'd99, 8'd10, ST_OK, 1);
    send(OP_ACC, 8'd20, 8'd0, 8'd30, ST_OK, 1);
    send(OP_ACC, 8'd250, 8'd0, 8'd24, ST_OVERFLOW, 1);
    send(te_operation'(3'd7), 8'd9, 8'd9, 8'd0, ST_INVALID, 1);
    send(OP_ACC, 8'd1, 8'd0, 8'd25, ST_OK, 1);
    drain();

    // Stream with a 3-cycle downstream stall at the first output.
    fork
      begin
        send(OP_ADD, 8'd1, 8'd1, 8'd2, ST_OK, 0);
        send(OP_ADD, 8'd2, 8'd2, 8'd4, ST_OK, 0);
        send(OP_ADD, 8'd3, 8'd3, 8'd6, ST_OK, 0);
        send(OP_ADD, 8'd4, 8'd4, 8'd8, ST_OK, 0);
      end
      begin
        int unsigned g;
        g = 0;
        while (!out_valid && g < 20) begin
          @(posedge clk);
          #1;
          g++;
        end
        check("stall_saw_out_valid", int'(out_valid), 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", int'(in_ready), 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operations in flight (acc is 25 here).
    send(OP_ACC, 8'd7, 8'd0, 8'd32, ST_OK, 0);
    send(OP_ADD, 8'd1, 8'd2, 8'd3, ST_OK, 0);
    sb.delete();
    reset = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_release_in_ready", int'(in_ready), 1);
    repeat (6) @(posedge clk);
    #1;
    send(OP_ACC, 8'd5, 8'd0, 8'd5, ST_OK, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
